// File: rtl/q3_tagged_demux_rx.sv
// Receive side of the tagged-word link: checks the marker bit and steers each payload
// into one of two first-word-fall-through channel FIFOs with per-channel overflow flags.

module q3_tagged_demux_fifo #(
    parameter int DATA_W = 7,
    parameter int DEPTH  = 4,
    parameter int LVL_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop_req,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic [LVL_W-1:0]  level,
    output logic              drop
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [LVL_W-1:0]  level_r;
    logic [DATA_W-1:0] data_r;

    logic              empty_s;
    logic              full_s;
    logic              pop_s;
    logic              push_ok_s;
    logic              drop_s;
    logic [PTR_W-1:0]  rd_inc_s;
    logic [LVL_W-1:0]  level_nxt_s;
    logic [DATA_W-1:0] data_nxt_s;

    // Handshake qualification, occupancy update and next head-of-queue value.
    always_comb begin
        empty_s     = (level_r == LVL_W'(0));
        full_s      = (level_r == LVL_W'(DEPTH));
        pop_s       = pop_req && !empty_s;
        // A pop on a full FIFO frees the slot the same-edge push lands in.
        push_ok_s   = push && (!full_s || pop_s);
        drop_s      = push && full_s && !pop_s;
        rd_inc_s    = rd_ptr_r + PTR_W'(1);
        level_nxt_s = level_r + LVL_W'(push_ok_s) - LVL_W'(pop_s);
        data_nxt_s  = data_r;
        if (pop_s) begin
            if (level_r > LVL_W'(1)) begin
                data_nxt_s = mem_r[rd_inc_s];
            end else if (push_ok_s) begin
                data_nxt_s = push_data;
            end else begin
                data_nxt_s = data_r;
            end
        end else if (empty_s && push_ok_s) begin
            data_nxt_s = push_data;
        end else begin
            data_nxt_s = data_r;
        end
    end

    // Pointer, level and registered head-data state; head holds its value when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= PTR_W'(0);
            wr_ptr_r <= PTR_W'(0);
            level_r  <= LVL_W'(0);
            data_r   <= DATA_W'(0);
        end else begin
            if (pop_s) begin
                rd_ptr_r <= rd_inc_s;
            end
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            level_r <= level_nxt_s;
            data_r  <= data_nxt_s;
        end
    end

    // Storage array; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign data  = data_r;
    assign valid = !empty_s;
    assign level = level_r;
    assign drop  = drop_s;
endmodule

module q3_tagged_demux_rx #(
    parameter int DATA_W = 7,
    parameter int DEPTH  = 4,
    parameter int ERR_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [DATA_W:0]            in_word,
    input  logic                       in_sel,
    input  logic                       clr,
    output logic [DATA_W-1:0]          a_data,
    output logic                       a_valid,
    input  logic                       a_ready,
    output logic [DATA_W-1:0]          b_data,
    output logic                       b_valid,
    input  logic                       b_ready,
    output logic [$clog2(DEPTH):0]     a_level,
    output logic [$clog2(DEPTH):0]     b_level,
    output logic [ERR_W-1:0]           err_cnt,
    output logic                       ovf_a,
    output logic                       ovf_b
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    logic              marker_ok_s;
    logic              bad_s;
    logic              push_a_s;
    logic              push_b_s;
    logic              drop_a_s;
    logic              drop_b_s;
    logic [ERR_W-1:0]  err_cnt_r;
    logic              ovf_a_r;
    logic              ovf_b_r;

    // Marker check and channel steering of qualified words.
    always_comb begin
        marker_ok_s = in_word[DATA_W];
        bad_s       = in_valid && !marker_ok_s;
        push_a_s    = in_valid && marker_ok_s && !in_sel;
        push_b_s    = in_valid && marker_ok_s && in_sel;
    end

    q3_tagged_demux_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) u_fifo_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_a_s),
        .push_data (in_word[DATA_W-1:0]),
        .pop_req   (a_ready),
        .data      (a_data),
        .valid     (a_valid),
        .level     (a_level),
        .drop      (drop_a_s)
    );

    q3_tagged_demux_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) u_fifo_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_b_s),
        .push_data (in_word[DATA_W-1:0]),
        .pop_req   (b_ready),
        .data      (b_data),
        .valid     (b_valid),
        .level     (b_level),
        .drop      (drop_b_s)
    );

    // Saturating error counter and sticky overflow flags; clr wins over any same-edge event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= ERR_W'(0);
            ovf_a_r   <= 1'b0;
            ovf_b_r   <= 1'b0;
        end else if (clr) begin
            err_cnt_r <= ERR_W'(0);
            ovf_a_r   <= 1'b0;
            ovf_b_r   <= 1'b0;
        end else begin
            if (bad_s) begin
                err_cnt_r <= sat_inc(err_cnt_r);
            end
            if (drop_a_s) begin
                ovf_a_r <= 1'b1;
            end
            if (drop_b_s) begin
                ovf_b_r <= 1'b1;
            end
        end
    end

    assign err_cnt = err_cnt_r;
    assign ovf_a   = ovf_a_r;
    assign ovf_b   = ovf_b_r;
endmodule

// File: tb/tb_q3_tagged_demux_rx.sv
// Scoreboard bench for q3_tagged_demux_rx: expected payloads are queued at issue time
// and a negedge monitor checks every accepted pop against them.

module tb_q3_tagged_demux_rx;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_word;
    logic       in_sel;
    logic       clr;
    logic [6:0] a_data, b_data;
    logic       a_valid, b_valid;
    logic       a_ready, b_ready;
    logic [2:0] a_level, b_level;
    logic [7:0] err_cnt;
    logic       ovf_a, ovf_b;

    int checks = 0;
    int errors = 0;
    logic [6:0] exp_a[$];
    logic [6:0] exp_b[$];

    always #5 clk = ~clk;

    q3_tagged_demux_rx #(.DATA_W(7), .DEPTH(4), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_word(in_word),
        .in_sel(in_sel), .clr(clr), .a_data(a_data), .a_valid(a_valid),
        .a_ready(a_ready), .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .a_level(a_level), .b_level(b_level), .err_cnt(err_cnt),
        .ovf_a(ovf_a), .ovf_b(ovf_b)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: every pop the DUT will take at the next edge is compared with the scoreboard.
    always @(negedge clk) begin
        if (rst_n && a_valid && a_ready) begin
            checks++;
            if (exp_a.size() == 0) begin
                errors++;
                $display("FAIL pop_a: actual %0h required none", a_data);
            end else begin
                logic [6:0] e;
                e = exp_a.pop_front();
                if (a_data != e) begin
                    errors++;
                    $display("FAIL pop_a: actual %0h required %0h", a_data, e);
                end
            end
        end
        if (rst_n && b_valid && b_ready) begin
            checks++;
            if (exp_b.size() == 0) begin
                errors++;
                $display("FAIL pop_b: actual %0h required none", b_data);
            end else begin
                logic [6:0] e;
                e = exp_b.pop_front();
                if (b_data != e) begin
                    errors++;
                    $display("FAIL pop_b: actual %0h required %0h", b_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one word; exp_acc says whether the bench expects the payload to be stored.
    task automatic send(input logic [7:0] w, input logic sel, input logic exp_acc);
        logic [6:0] p;
        p = w[6:0];
        in_valid = 1'b1;
        in_word  = w;
        in_sel   = sel;
        if (exp_acc) begin
            if (sel) exp_b.push_back(p);
            else     exp_a.push_back(p);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input logic sel);
        bit done;
        done = 1'b0;
        if (sel) b_ready = 1'b1;
        else     a_ready = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if ((sel ? b_level : a_level) == 3'd0) done = 1'b1;
        end
        a_ready = 1'b0;
        b_ready = 1'b0;
        check(sel ? "drain_b_timeout" : "drain_a_timeout", int'(done), 1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_word = 8'h00; in_sel = 1'b0;
        clr = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
        repeat (3) tick();
        check("rst_a_valid", a_valid, 0);
        check("rst_b_valid", b_valid, 0);
        check("rst_a_data", a_data, 0);
        check("rst_b_data", b_data, 0);
        check("rst_levels", {a_level, b_level}, 0);
        check("rst_err", err_cnt, 0);
        check("rst_ovf", {ovf_a, ovf_b}, 0);
        rst_n = 1'b1;
        tick();

        send(8'h85, 1'b0, 1'b1);
        check("first_a_valid", a_valid, 1);
        check("first_a_data", a_data, 7'h05);
        check("first_a_level", a_level, 1);
        check("first_b_valid", b_valid, 0);
        drain(1'b0);

        send(8'h81, 1'b0, 1'b1);
        send(8'h82, 1'b0, 1'b1);
        send(8'hFF, 1'b1, 1'b1);
        check("route_a_level", a_level, 2);
        check("route_b_level", b_level, 1);
        check("route_b_data", b_data, 7'h7F);
        drain(1'b0);
        drain(1'b1);
        check("route_levels_zero", {a_level, b_level}, 0);
        check("hold_a_data", a_data, 7'h02);
        check("hold_a_valid", a_valid, 0);

        repeat (3) send(8'h05, 1'b0, 1'b0);
        check("err_3", err_cnt, 3);
        check("err_fifo_empty", {a_level, b_level}, 0);
        repeat (260) send(8'h05, 1'b1, 1'b0);
        check("err_saturate", err_cnt, 8'hFF);
        check("err_b_empty", b_level, 0);
        clr = 1'b1; tick(); clr = 1'b0;
        check("err_clr", err_cnt, 0);
        clr = 1'b1; send(8'h05, 1'b0, 1'b0); clr = 1'b0;
        check("clr_priority", err_cnt, 0);

        send(8'h91, 1'b1, 1'b1);
        send(8'h92, 1'b1, 1'b1);
        send(8'h93, 1'b1, 1'b1);
        send(8'h94, 1'b1, 1'b1);
        send(8'h95, 1'b1, 1'b0);
        check("ovf_b_level", b_level, 4);
        check("ovf_b_set", ovf_b, 1);
        check("ovf_a_clear", ovf_a, 0);
        drain(1'b1);
        check("ovf_fifth_absent", exp_b.size(), 0);
        check("ovf_b_sticky", ovf_b, 1);
        clr = 1'b1; tick(); clr = 1'b0;
        check("ovf_clr", ovf_b, 0);

        send(8'h91, 1'b1, 1'b1);
        send(8'h92, 1'b1, 1'b1);
        send(8'h93, 1'b1, 1'b1);
        send(8'h94, 1'b1, 1'b1);
        b_ready = 1'b1;
        send(8'h99, 1'b1, 1'b1);
        b_ready = 1'b0;
        check("fullpp_level", b_level, 4);
        check("fullpp_ovf", ovf_b, 0);
        check("fullpp_head", b_data, 7'h12);
        drain(1'b1);
        check("fullpp_last_data", b_data, 7'h19);

        a_ready = 1'b1;
        send(8'h8A, 1'b0, 1'b1);
        a_ready = 1'b0;
        check("emptypp_level", a_level, 1);
        check("emptypp_data", a_data, 7'h0A);
        a_ready = 1'b1;
        send(8'h83, 1'b0, 1'b1);
        a_ready = 1'b0;
        check("pp_level", a_level, 1);
        check("pp_data", a_data, 7'h03);
        check("pp_b_untouched", b_level, 0);

        send(8'h84, 1'b0, 1'b1);
        send(8'h86, 1'b0, 1'b1);
        check("pre_rst_level", a_level, 3);
        @(posedge clk);
        #3 rst_n = 1'b0;
        exp_a.delete();
        #1;
        check("async_rst_valid", a_valid, 0);
        check("async_rst_level", a_level, 0);
        check("async_rst_data", a_data, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", {a_valid, b_valid}, 0);
        check("sb_a_empty", exp_a.size(), 0);
        check("sb_b_empty", exp_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/q3_tagged_demux_rx.md
Name: q3_tagged_demux_rx

Overview:
- Receive-side counterpart to the team's registered 2:1 tagged-word mux.
- The mux emits an 8-bit word: bit 7 is a fixed marker (always 1) and bits 6:0 are the payload taken from one of two sources.
- This block accepts those words, checks the marker, and routes each payload back to one of two output channels (A/B) by a sideband select.
- Each channel is buffered in its own FIFO with a valid/ready handshake; the block also counts marker errors and flags overflow.

Parameters:
- DATA_W, 7, payload width; the marker bit is in_word[DATA_W].
- DEPTH, 4, entries per channel FIFO; must be a power of 2 and ≥ 2.
- ERR_W, 8, width of the saturating marker-error counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_word/in_sel are valid this cycle; there is no backpressure.
- in_word  in  DATA_W+1  bit DATA_W = marker, bits DATA_W-1:0 = payload.
- in_sel  in  1  0 routes to channel A, 1 routes to channel B.
- clr  in  1  synchronous clear of err_cnt, ovf_a and ovf_b.
- a_data  out  DATA_W  channel A head payload.
- a_valid  out  1  channel A FIFO not empty.
- a_ready  in  1  channel A consumer accepts the head entry.
- b_data  out  DATA_W  channel B head payload.
- b_valid  out  1  channel B FIFO not empty.
- b_ready  in  1  channel B consumer accepts the head entry.
- a_level  out  log2(DEPTH)+1  channel A occupancy.
- b_level  out  log2(DEPTH)+1  channel B occupancy.
- err_cnt  out  ERR_W  count of words discarded for a bad marker.
- ovf_a  out  1  sticky: a channel A word was dropped because the FIFO was full.
- ovf_b  out  1  sticky: a channel B word was dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - Both FIFOs empty; pointers and levels = 0.
  - a_valid = b_valid = 0; a_data = b_data = 0.
  - err_cnt = 0; ovf_a = ovf_b = 0.
  - Entries in flight are lost. The first edge after deassertion behaves as normal operation.
- Input qualification, sampled each edge with in_valid = 1:
  - Marker = 0: word discarded; err_cnt += 1, saturating at all-ones with no wrap; no FIFO change.
  - Marker = 1: payload pushed to the FIFO selected by in_sel.
  - in_valid = 0: in_word and in_sel are ignored.
- Latency: a word pushed into an empty FIFO at edge N gives valid = 1 and data = payload immediately after edge N (1-cycle latency, registered).
- FIFO is first-word-fall-through: x_data always shows the oldest entry while x_valid = 1.
  - When x_valid = 0, x_data holds its last value; it is never X.
- Pop: at an edge where x_valid and x_ready are both 1, the head entry is removed; x_ready while x_valid = 0 has no effect.
- Simultaneous push and pop, same channel:
  - Not full: level unchanged; data order preserved.
  - Empty: no pop happens; push proceeds normally.
  - Full: the pop frees a slot, so the push is accepted; level stays DEPTH; no overflow.
- Push to a full FIFO without a pop: payload dropped; ovf_x set to 1 and held until clr or reset; FIFO contents untouched.
- Pointers wrap modulo DEPTH; level ranges 0..DEPTH inclusive.
- Channels are independent: a push to A never affects B's state or handshake, and vice versa.
- clr (synchronous):
  - Next edge: err_cnt = 0, ovf_a = ovf_b = 0; FIFOs unaffected.
  - clr has priority over a same-cycle increment or set, so the result is 0.
- Outputs are registered or derived only from registered state; there is no combinational path from any input to any output.

Test Plan:
- Reset then idle: rst_n low 3 cycles → all outputs 0. Then push 0x85 with sel = 0 → next cycle a_valid = 1, a_data = 0x05, a_level = 1, b_valid = 0.
- Routing and order: push 0x81, 0x82 to A and 0xFF to B with a_ready = b_ready = 0 → A pops 0x01 then 0x02; B pops 0x7F; both levels return to 0.
- Marker error: push 0x05 (bit 7 = 0) three times → err_cnt = 3, FIFOs empty. With ERR_W = 2, eight bad words → err_cnt holds at 3. A clr pulse → 0.
- Overflow: push 5 marked words to B with DEPTH = 4 and b_ready = 0 → b_level = 4, ovf_b = 1, ovf_a = 0. Pops return the first 4 payloads; the 5th is absent.
- Full plus simultaneous pop/push: B full, b_ready = 1 with a new push of 0x99 → level stays 4, ovf_b stays 0, and 0x19 is popped last.
- Reset mid-operation: A at level 3; assert rst_n asynchronously mid-cycle → a_valid = 0 and a_level = 0 immediately, without waiting for a clock edge.
